// File: rtl/core_trap_ctrl_if.sv
// Request and redirect channels of the trap/xRET sequencer.
// slave = the sequencer, master = the requester / fetch side.
interface core_trap_ctrl_if #(
    parameter int CAUSE_W = 5
);
    logic               req_valid;
    logic               req_ready;
    logic               req_is_xret;
    logic               req_xret_is_mret;
    logic               req_is_interrupt;
    logic [CAUSE_W-1:0] req_cause;
    logic [31:0]        req_epc;
    logic [31:0]        req_tval;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               redirect_ready;

    modport slave (
        input  req_valid, req_is_xret, req_xret_is_mret, req_is_interrupt,
               req_cause, req_epc, req_tval, redirect_ready,
        output req_ready, redirect_valid, redirect_pc
    );

    modport master (
        output req_valid, req_is_xret, req_xret_is_mret, req_is_interrupt,
               req_cause, req_epc, req_tval, redirect_ready,
        input  req_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/core_trap_ctrl.sv
// Trap-entry / xRET sequencer: snapshot request, one-cycle CSR commit, held redirect.
// Define LETC_TRAP_VECTORED_EN to enable vectored interrupt entry (tvec mode 01).
module core_trap_ctrl #(
    parameter int CAUSE_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    core_trap_ctrl_if.slave bus,
    input  logic [1:0]  prv_mode,
    input  logic [31:0] csr_mstatus_ff,
    input  logic [31:0] csr_medeleg_ff,
    input  logic [31:0] csr_mideleg_ff,
    input  logic [31:0] csr_mtvec_ff,
    input  logic [31:0] csr_stvec_ff,
    input  logic [31:0] csr_mepc_ff,
    input  logic [31:0] csr_sepc_ff,
    output logic [1:0]  prv_mode_wd,
    output logic        prv_mode_we,
    output logic [31:0] csr_mstatus_wd,
    output logic        csr_mstatus_we,
    output logic [31:0] csr_mepc_wd,
    output logic        csr_mepc_we,
    output logic [31:0] csr_mcause_wd,
    output logic        csr_mcause_we,
    output logic [31:0] csr_sepc_wd,
    output logic        csr_sepc_we,
    output logic [31:0] csr_scause_wd,
    output logic        csr_scause_we,
    output logic [31:0] csr_stval_wd,
    output logic        csr_stval_we
);
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_COMMIT = 2'b01;
    localparam logic [1:0] S_REDIR  = 2'b10;
    localparam logic [1:0] PRV_S    = 2'b01;
    localparam logic [1:0] PRV_M    = 2'b11;

    logic [1:0]         state_q, state_d;
    logic               is_xret_q, is_mret_q, is_int_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [31:0]        epc_q, tval_q;
    logic [1:0]         prv_q;
    logic [31:0]        mstatus_q, medeleg_q, mideleg_q, mtvec_q, stvec_q, mepc_q, sepc_q;
    logic [31:0]        redir_pc_q, redir_pc_d;

    logic        accept, commit, cause_ok, to_s;
    logic [4:0]  cause_idx;
    logic [31:0] deleg_bits, cause_ext, cause_word, tvec, base, trap_pc, ms_n;
    logic [1:0]  prv_n;

    assign accept = bus.req_valid && (state_q == S_IDLE);
    assign commit = (state_q == S_COMMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_COMMIT;
            S_COMMIT: state_d = S_REDIR;
            S_REDIR:  if (bus.redirect_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            is_xret_q  <= 1'b0;
            is_mret_q  <= 1'b0;
            is_int_q   <= 1'b0;
            cause_q    <= '0;
            epc_q      <= '0;
            tval_q     <= '0;
            prv_q      <= '0;
            mstatus_q  <= '0;
            medeleg_q  <= '0;
            mideleg_q  <= '0;
            mtvec_q    <= '0;
            stvec_q    <= '0;
            mepc_q     <= '0;
            sepc_q     <= '0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
            if (accept) begin
                is_xret_q <= bus.req_is_xret;
                is_mret_q <= bus.req_xret_is_mret;
                is_int_q  <= bus.req_is_interrupt;
                cause_q   <= bus.req_cause;
                epc_q     <= bus.req_epc;
                tval_q    <= bus.req_tval;
                prv_q     <= prv_mode;
                mstatus_q <= csr_mstatus_ff;
                medeleg_q <= csr_medeleg_ff;
                mideleg_q <= csr_mideleg_ff;
                mtvec_q   <= csr_mtvec_ff;
                stvec_q   <= csr_stvec_ff;
                mepc_q    <= csr_mepc_ff;
                sepc_q    <= csr_sepc_ff;
            end
        end
    end

    // Delegation registers are 32 bits wide; wider cause codes always trap to M.
    generate
        if (CAUSE_W > 5) begin : g_wide
            assign cause_ok = ~|cause_q[CAUSE_W-1:5];
        end else begin : g_narrow
            assign cause_ok = 1'b1;
        end
    endgenerate

    assign cause_idx  = 5'(cause_q);
    assign cause_ext  = 32'(cause_q);
    assign cause_word = cause_ext | {is_int_q, 31'b0};
    assign deleg_bits = is_int_q ? mideleg_q : medeleg_q;
    assign to_s       = !is_xret_q && (prv_q != PRV_M) && cause_ok && deleg_bits[cause_idx];
    assign tvec       = to_s ? stvec_q : mtvec_q;
    assign base       = tvec & ~32'h3;

`ifdef LETC_TRAP_VECTORED_EN
    assign trap_pc = (tvec[1:0] == 2'b01 && is_int_q) ? base + (cause_ext << 2) : base;
`else
    assign trap_pc = base;
`endif

    always_comb begin
        ms_n  = mstatus_q;
        prv_n = PRV_M;
        if (is_xret_q && is_mret_q) begin
            prv_n       = mstatus_q[12:11];
            ms_n[3]     = mstatus_q[7];
            ms_n[7]     = 1'b1;
            ms_n[12:11] = 2'b00;
            if (mstatus_q[12:11] != PRV_M) ms_n[17] = 1'b0;
        end else if (is_xret_q) begin
            prv_n   = {1'b0, mstatus_q[8]};
            ms_n[1] = mstatus_q[5];
            ms_n[5] = 1'b1;
            ms_n[8] = 1'b0;
            ms_n[17] = 1'b0;
        end else if (to_s) begin
            prv_n   = PRV_S;
            ms_n[5] = mstatus_q[1];
            ms_n[1] = 1'b0;
            ms_n[8] = prv_q[0];
        end else begin
            ms_n[7]     = mstatus_q[3];
            ms_n[3]     = 1'b0;
            ms_n[12:11] = prv_q;
        end
    end

    always_comb begin
        redir_pc_d = redir_pc_q;
        if (commit) begin
            if (!is_xret_q)    redir_pc_d = trap_pc;
            else if (is_mret_q) redir_pc_d = mepc_q;
            else               redir_pc_d = sepc_q;
        end
    end

    // Write data is forced to zero outside the commit cycle.
    assign prv_mode_we    = commit;
    assign csr_mstatus_we = commit;
    assign csr_mepc_we    = commit && !is_xret_q && !to_s;
    assign csr_mcause_we  = csr_mepc_we;
    assign csr_sepc_we    = commit && to_s;
    assign csr_scause_we  = csr_sepc_we;
    assign csr_stval_we   = csr_sepc_we;

    assign prv_mode_wd    = commit ? prv_n : 2'b00;
    assign csr_mstatus_wd = commit ? ms_n : 32'h0;
    assign csr_mepc_wd    = csr_mepc_we ? (epc_q & ~32'h3) : 32'h0;
    assign csr_mcause_wd  = csr_mcause_we ? cause_word : 32'h0;
    assign csr_sepc_wd    = csr_sepc_we ? (epc_q & ~32'h3) : 32'h0;
    assign csr_scause_wd  = csr_scause_we ? cause_word : 32'h0;
    assign csr_stval_wd   = csr_stval_we ? tval_q : 32'h0;

    assign bus.req_ready      = (state_q == S_IDLE);
    assign bus.redirect_valid = (state_q == S_REDIR);
    assign bus.redirect_pc    = redir_pc_q;
endmodule

// File: doc/core_trap_ctrl.md
Name: core_trap_ctrl

Overview:
- Trap-entry and xRET sequencer. It is the consumer of the CSR file's implicitly-read CSRs and the driver of its implicitly-written CSRs.
- Accepts one trap or xRET request at a time, resolves delegation and target privilege, and computes the new mstatus.
- Pulses the CSR/privilege write-enables for exactly one cycle, then holds a PC redirect toward fetch until it is accepted.

Parameters:
- CAUSE_W, 5, width of the exception/interrupt code field.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  trap or xRET request
- req_ready  out  1  high only in IDLE
- req_is_xret  in  1  1=xRET, 0=trap
- req_xret_is_mret  in  1  1=MRET, 0=SRET (valid when req_is_xret)
- req_is_interrupt  in  1  trap is an interrupt
- req_cause  in  CAUSE_W  exception/interrupt code
- req_epc  in  32  faulting/interrupted PC
- req_tval  in  32  trap value
- prv_mode  in  2  current privilege (U=00, S=01, M=11)
- csr_mstatus_ff, csr_medeleg_ff, csr_mideleg_ff, csr_mtvec_ff, csr_stvec_ff, csr_mepc_ff, csr_sepc_ff  in  32 each  current CSR values
- prv_mode_wd  out  2; prv_mode_we  out  1
- csr_mstatus_wd  out  32; csr_mstatus_we  out  1
- csr_mepc_wd, csr_mcause_wd, csr_sepc_wd, csr_scause_wd, csr_stval_wd  out  32 each; matching *_we  out  1 each
- redirect_valid  out  1; redirect_pc  out  32; redirect_ready  in  1

Behaviour:
- Reset: state=IDLE, req_ready=1, all *_we=0, redirect_valid=0, all *_wd=0, redirect_pc=0. rst_n asserted in any state returns to IDLE immediately and drops every we/valid.
- FSM IDLE -> COMMIT -> REDIRECT -> IDLE.
  - IDLE: on req_valid&&req_ready, register all req_* fields, prv_mode and the CSR inputs, then go to COMMIT. Later changes to these inputs are ignored.
  - COMMIT: exactly one cycle. Assert the relevant *_we with *_wd computed from the snapshot; compute redirect_pc. Go to REDIRECT.
  - REDIRECT: redirect_valid=1 with redirect_pc stable. On redirect_ready go to IDLE. redirect_ready in the same cycle as the first redirect_valid completes the redirect.
- Latency: accept in cycle N, CSR writes in N+1, redirect_valid from N+2. The next request can be accepted the cycle after the redirect handshake.
- Delegation (traps only):
  - target=S iff prv_mode!=M and bit[cause] of (interrupt ? mideleg : medeleg) is 1; otherwise target=M.
  - Cause codes >=32 are never delegated.
- Trap to M: write
  - mepc=epc&~3
  - mcause={is_interrupt, zero-fill, cause}
  - mstatus with MPIE[7]=MIE[3], MIE=0, MPP[12:11]=prv_mode
  - prv_mode=M
  - No tval write.
- Trap to S: write
  - sepc, scause as above
  - stval=tval
  - mstatus with SPIE[5]=SIE[1], SIE=0, SPP[8]=prv_mode[0]
  - prv_mode=S
- Trap target PC: base=tvec&~3. redirect_pc=base (direct; see optional feature).
- MRET:
  - prv_mode=MPP; MIE=MPIE; MPIE=1; MPP=U
  - MPRV[17]=0 if MPP!=M
  - redirect_pc=mepc
- SRET:
  - prv_mode={1'b0,SPP}; SIE=SPIE; SPIE=1; SPP=0; MPRV=0
  - redirect_pc=sepc
- All mstatus bits not named above are passed through unchanged.
- Privilege legality of xRET is checked upstream. Illegal xRETs arrive here as traps.
- The request is a single channel; req_is_xret decides whether it is a trap or an xRET.

Optional Feature:
- LETC_TRAP_VECTORED_EN defined: when tvec[1:0]==01 and the trap is an interrupt, redirect_pc=base+4*cause. Exceptions still use base.
- Not defined: tvec[1:0] is ignored and all traps go to base.
- Mode values 10/11 are treated as direct in both builds.

Test Plan:
- Reset, no requests -> req_ready=1, all *_we=0, redirect_valid=0.
- U-mode illegal-instr (cause=2, epc=0x8000_0104), medeleg=0, mtvec=0x8000_0000, mstatus.MIE=1 -> N+1: mepc=0x8000_0104, mcause=0x2, MPP=00, MPIE=1, MIE=0, prv=M for one cycle; N+2: redirect_pc=0x8000_0000.
- Same request with medeleg bit2=1 -> sepc/scause/stval written, mepc_we=0, SPP=0, prv=S, redirect_pc=stvec&~3. From M-mode with the same delegation -> M target.
- Timer interrupt cause=7, mtvec=0x8000_0001 -> with LETC_TRAP_VECTORED_EN redirect_pc=0x8000_001C; without it, 0x8000_0000.
- MRET with MPP=01, MPIE=1, MPRV=1, mepc=0x8000_2000 -> prv=S, MIE=1, MPIE=1, MPP=00, MPRV=0, redirect_pc=0x8000_2000.
- Hold redirect_ready=0 for 5 cycles -> redirect_valid and redirect_pc stable, req_ready=0, no repeated we pulses. Assert rst_n low mid-REDIRECT -> IDLE, redirect_valid=0 immediately.
